// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI encodings for the read arbiter: burst types, the word beat size,
// response codes, and the AR slot state type.
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set req bit at or after ptr,
// wrapping modulo N.
// Ports:
//   req     in  N   request vector
//   ptr     in  IW  starting index for the search
//   en      in  1   0 forces no grant
//   gnt     out N   one-hot grant
//   gnt_idx out IW  index of the granted bit (0 when nothing is granted)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (en && !found && req[idx]) begin
                found   = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Round-robin arbiter from NUM_MASTER cache read ports onto one AXI AR channel,
// with R beats routed back by rid and per-master outstanding-read limits.
// Ports:
//   clk, reset                    clock, async active-low reset
//   m_rd_req/addr/size, m_burst   per-master read requests (held until m_rd_rdy)
//   m_rd_rdy                      one-hot combinational grant pulse
//   m_ret_valid/last/data/err     R beat routed to the master named by rid
//   wr_idle                       0 blocks new grants (a FULL slot still drains)
//   rid_err                       sticky: bad rid or rlast with nothing outstanding
//   ar*                           registered AR channel (arlock/cache/prot = 0)
//   rid/rdata/rresp/rlast/rvalid  R channel in; rready tied to 1
// -----------------------------------------------------------------------------
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int NUM_MASTER = 2,
    parameter int ID_WIDTH   = 4,
    parameter int LINE_WORDS = 4,
    parameter int MAX_OUTS   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_MASTER-1:0]    m_rd_req,
    input  logic [NUM_MASTER*32-1:0] m_rd_addr,
    input  logic [NUM_MASTER*2-1:0]  m_rd_size,
    input  logic [NUM_MASTER-1:0]    m_burst,
    output logic [NUM_MASTER-1:0]    m_rd_rdy,
    output logic [NUM_MASTER-1:0]    m_ret_valid,
    output logic                     m_ret_last,
    output logic [31:0]              m_ret_data,
    output logic                     m_ret_err,
    input  logic                     wr_idle,
    output logic                     rid_err,
    output logic [ID_WIDTH-1:0]      arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [ID_WIDTH-1:0]      rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    localparam int IW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
    localparam int CW = $clog2(MAX_OUTS + 1);

    slot_e                             slot_q, slot_d;
    logic [ID_WIDTH-1:0]               arid_q, arid_d;
    logic [31:0]                       araddr_q, araddr_d;
    logic [7:0]                        arlen_q, arlen_d;
    logic [2:0]                        arsize_q, arsize_d;
    logic [1:0]                        arburst_q, arburst_d;
    logic [IW-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTER-1:0][CW-1:0]     cnt_q, cnt_d;
    logic                              rid_err_q, rid_err_d;

    logic [NUM_MASTER-1:0][31:0]       addr_v;
    logic [NUM_MASTER-1:0][1:0]        size_v;
    logic [NUM_MASTER-1:0]             elig;
    logic [NUM_MASTER-1:0]             gnt;
    logic [IW-1:0]                     gnt_idx;
    logic                              gnt_en;
    logic                              ar_hs;
    logic                              rid_ok;
    logic                              ret_last;
    logic                              unused_rresp0;

    assign addr_v        = m_rd_addr;
    assign size_v        = m_rd_size;
    assign unused_rresp0 = rresp[0];

    assign ar_hs    = (slot_q == SLOT_FULL) && arready;
    assign rid_ok   = int'(rid) < NUM_MASTER;
    assign ret_last = rvalid && rlast && rid_ok;

    // A read counts against its master from grant onward: the one sitting in
    // the AR slot is included, otherwise back-to-back grants would overshoot
    // MAX_OUTS before the handshake registers. An rlast this cycle frees its
    // credit immediately so the next read can be granted in the same cycle.
    always_comb begin
        logic pend;
        logic done;
        elig = '0;
        pend = 1'b0;
        done = 1'b0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            pend    = (slot_q == SLOT_FULL) && (arid_q == ID_WIDTH'(i));
            done    = ret_last && (rid == ID_WIDTH'(i));
            elig[i] = m_rd_req[i] &&
                      ((int'(cnt_q[i]) + (pend ? 1 : 0) - (done ? 1 : 0)) < MAX_OUTS);
        end
    end

    // Gating with reset keeps the combinational grant quiet while in reset.
    assign gnt_en = reset && wr_idle && ((slot_q == SLOT_EMPTY) || arready);

    rr_arbiter #(.N(NUM_MASTER), .IW(IW)) u_rr (
        .req     (elig),
        .ptr     (rr_ptr_q),
        .en      (gnt_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // AR slot next state and payload load.
    always_comb begin
        slot_d    = slot_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rr_ptr_d  = rr_ptr_q;
        if (ar_hs) begin
            slot_d = SLOT_EMPTY;
        end
        if (|gnt) begin
            slot_d   = SLOT_FULL;
            arid_d   = ID_WIDTH'(gnt_idx);
            araddr_d = addr_v[gnt_idx];
            if (m_burst[gnt_idx]) begin
                arburst_d = BURST_INCR;
                arsize_d  = SIZE_WORD;
                arlen_d   = 8'(LINE_WORDS - 1);
            end else begin
                arburst_d = BURST_FIXED;
                arsize_d  = {1'b0, size_v[gnt_idx]};
                arlen_d   = 8'd0;
            end
            rr_ptr_d = (int'(gnt_idx) == NUM_MASTER - 1) ? '0 : IW'(int'(gnt_idx) + 1);
        end
    end

    // Outstanding counters; an rlast with nothing accepted saturates at 0.
    always_comb begin
        logic inc;
        logic dec;
        cnt_d     = cnt_q;
        rid_err_d = rid_err_q;
        inc       = 1'b0;
        dec       = 1'b0;
        if (rvalid && !rid_ok) begin
            rid_err_d = 1'b1;
        end
        for (int i = 0; i < NUM_MASTER; i++) begin
            inc = ar_hs && (arid_q == ID_WIDTH'(i));
            dec = ret_last && (rid == ID_WIDTH'(i));
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) begin
                    rid_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q    <= SLOT_EMPTY;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            rid_err_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            rid_err_q <= rid_err_d;
        end
    end

    always_comb begin
        m_ret_valid = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            m_ret_valid[i] = reset && rvalid && (rid == ID_WIDTH'(i));
        end
    end

    assign m_rd_rdy   = gnt;
    assign m_ret_last = reset && rlast;
    assign m_ret_data = rdata & {32{reset}};
    assign m_ret_err  = reset && rresp[1];
    assign rid_err    = rid_err_q;

    assign arvalid = (slot_q == SLOT_FULL);
    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = arburst_q;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign rready  = 1'b1;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Randomized bench with a transaction-level reference model: per-master
// in-flight counts, a queue of accepted reads the slave serves beats from,
// and the AR slot contents as a plain record.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam int NM  = 2;
    localparam int IDW = 4;
    localparam int LW  = 4;
    localparam int MO  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NM-1:0]     m_rd_req;
    logic [NM*32-1:0]  m_rd_addr;
    logic [NM*2-1:0]   m_rd_size;
    logic [NM-1:0]     m_burst;
    logic [NM-1:0]     m_rd_rdy;
    logic [NM-1:0]     m_ret_valid;
    logic              m_ret_last;
    logic [31:0]       m_ret_data;
    logic              m_ret_err;
    logic              wr_idle;
    logic              rid_err;
    logic [IDW-1:0]    arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [IDW-1:0]    rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    axi_rd_arbiter #(.NUM_MASTER(NM), .ID_WIDTH(IDW), .LINE_WORDS(LW), .MAX_OUTS(MO)) dut (
        .clk(clk), .reset(reset),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_size(m_rd_size), .m_burst(m_burst),
        .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last),
        .m_ret_data(m_ret_data), .m_ret_err(m_ret_err), .wr_idle(wr_idle), .rid_err(rid_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit          slot_v;
    logic [3:0]  s_id;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    logic [2:0]  s_size;
    logic [1:0]  s_burst;
    int          rr;
    int          infl [NM];   // granted, last beat not yet returned
    int          hs   [NM];   // accepted on AR, last beat not yet returned
    bit          exp_err;
    int          acc_id[$];
    int          acc_beats[$];
    int          g_last;

    task automatic mdl_reset();
        slot_v = 0; s_id = '0; s_addr = '0; s_len = '0; s_size = '0; s_burst = '0;
        rr = 0; exp_err = 0; g_last = -1;
        for (int i = 0; i < NM; i++) begin infl[i] = 0; hs[i] = 0; end
        acc_id.delete(); acc_beats.delete();
    endtask

    // Evaluate one cycle at the falling edge, then advance to just past the
    // next rising edge where new stimulus is applied.
    task automatic tick();
        int ret_i, g, i;
        logic [NM-1:0] exp_rdy, exp_rv;
        bit can;
        @(negedge clk);
        ret_i = -1; exp_rv = '0; g = -1;
        if (rvalid && rid < NM) begin
            exp_rv = 2'b01 << rid;
            if (rlast) ret_i = int'(rid);
        end
        can = wr_idle && (!slot_v || arready);
        if (can) begin
            for (int k = 0; k < NM; k++) begin
                i = (rr + k) % NM;
                if (g < 0 && m_rd_req[i] && (infl[i] - ((ret_i == i) ? 1 : 0)) < MO) g = i;
            end
        end
        exp_rdy = (g >= 0) ? (2'b01 << g) : '0;
        chk("rdy", 64'(m_rd_rdy), 64'(exp_rdy));
        chk("ret_valid", 64'(m_ret_valid), 64'(exp_rv));
        chk("arvalid", 64'(arvalid), 64'(slot_v));
        chk("rid_err", 64'(rid_err), 64'(exp_err));
        if (slot_v)
            chk("ar_payload", 64'({arid, araddr, arlen, arsize, arburst}),
                64'({s_id, s_addr, s_len, s_size, s_burst}));
        if (rvalid)
            chk("ret_beat", 64'({m_ret_last, m_ret_err, m_ret_data}), 64'({rlast, rresp[1], rdata}));
        // next state
        if (rvalid && rid >= NM) exp_err = 1;
        if (slot_v && arready) begin
            hs[s_id]++;
            acc_id.push_back(int'(s_id));
            acc_beats.push_back(int'(s_len) + 1);
            slot_v = 0;
        end
        if (ret_i >= 0) begin
            if (hs[ret_i] == 0) exp_err = 1;
            else begin hs[ret_i]--; infl[ret_i]--; end
        end
        if (g >= 0) begin
            slot_v = 1;
            s_id   = 4'(g);
            s_addr = m_rd_addr[32*g +: 32];
            if (m_burst[g]) begin
                s_burst = 2'b01; s_size = 3'd2; s_len = 8'(LW - 1);
            end else begin
                s_burst = 2'b00; s_size = {1'b0, m_rd_size[2*g +: 2]}; s_len = 8'd0;
            end
            infl[g]++;
            rr = (g + 1) % NM;
        end
        g_last = g;
        @(posedge clk);
        #1;
    endtask

    // Slave: issue the next beat of the oldest accepted read of master id.
    task automatic serve_head(input int id);
        for (int k = 0; k < acc_id.size(); k++) begin
            if (acc_id[k] == id) begin
                rvalid = 1'b1;
                rid    = 4'(id);
                rlast  = (acc_beats[k] == 1);
                rdata  = $urandom;
                rresp  = 2'($urandom_range(0, 3));
                acc_beats[k]--;
                if (acc_beats[k] == 0) begin
                    acc_id.delete(k);
                    acc_beats.delete(k);
                end
                break;
            end
        end
    endtask

    task automatic drive_rand(input int p_req, input bit allow_r);
        int j;
        for (int i = 0; i < NM; i++) begin
            if (!m_rd_req[i] || g_last == i) begin
                m_rd_req[i]          = ($urandom_range(0, 99) < p_req);
                m_rd_addr[32*i +: 32] = $urandom;
                m_rd_size[2*i +: 2]   = 2'($urandom_range(0, 2));
                m_burst[i]           = 1'($urandom_range(0, 1));
            end
        end
        wr_idle = ($urandom_range(0, 7) != 0);
        arready = ($urandom_range(0, 3) != 0);
        rvalid = 1'b0; rid = '0; rlast = 1'b0; rdata = $urandom; rresp = 2'($urandom_range(0, 3));
        if (allow_r && acc_id.size() > 0 && $urandom_range(0, 2) != 0) begin
            j = $urandom_range(0, acc_id.size() - 1);
            serve_head(acc_id[j]);
        end
    endtask

    task automatic r_idle();
        rvalid = 1'b0; rid = '0; rlast = 1'b0; rdata = '0; rresp = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        int bound;
        mdl_reset();
        reset = 1'b0;
        m_rd_req = 2'b11; m_rd_addr = {32'h1234_5678, 32'h9abc_def0}; m_rd_size = '0; m_burst = '0;
        wr_idle = 1'b1; arready = 1'b1;
        rvalid = 1'b1; rid = '0; rlast = 1'b1; rdata = '0; rresp = '0;
        #3;
        chk("rst_arvalid", 64'(arvalid), 64'(0));
        chk("rst_payload", 64'({arid, araddr, arlen, arsize, arburst}), 64'(0));
        chk("rst_rdy", 64'(m_rd_rdy), 64'(0));
        chk("rst_ret_valid", 64'(m_ret_valid), 64'(0));
        chk("rst_rid_err", 64'(rid_err), 64'(0));
        chk("const_ar", 64'({arlock, arcache, arprot, rready}), 64'(1));
        @(posedge clk); #1;
        m_rd_req = '0; r_idle();
        reset = 1'b1;

        // single read from master 1
        m_rd_req = 2'b10; m_rd_addr[63:32] = 32'h1c00_0010; m_rd_size[3:2] = 2'd2; m_burst[1] = 1'b0;
        tick();
        m_rd_req = '0;
        chk("single_ar", 64'({arvalid, arid, arlen, arburst, arsize}), 64'({1'b1, 4'd1, 8'd0, 2'b00, 3'd2}));
        tick();
        serve_head(1);
        #1;
        chk("single_ret", 64'(m_ret_valid), 64'(2'b10));
        tick();
        r_idle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive_rand(60, 1'b1);
            tick();
        end

        // drain everything
        bound = 0;
        while ((acc_id.size() > 0 || slot_v || m_rd_req != '0) && bound < 400) begin
            drive_rand(0, 1'b1);
            tick();
            bound++;
        end
        chk("drain_in_bound", 64'(bound < 400), 64'(1));
        r_idle(); wr_idle = 1'b1; arready = 1'b1;

        // out-of-range rid
        rvalid = 1'b1; rid = 4'd5; rlast = 1'b1;
        #1;
        chk("bad_rid_no_route", 64'(m_ret_valid), 64'(0));
        tick();
        r_idle();
        tick();
        chk("rid_err_sticky", 64'(rid_err), 64'(1));

        // outstanding limit: master 0 bursts with R withheld
        m_rd_req = 2'b01; m_burst = 2'b01; m_rd_addr[31:0] = 32'h0000_4000;
        ng = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (m_rd_rdy[0]) ng++;
            tick();
        end
        chk("outs_limit_grants", 64'(ng), 64'(MO));
        for (int b = 0; b < LW; b++) begin
            serve_head(0);
            #1;
            chk("grant_vs_rlast", 64'(m_rd_rdy), 64'((b == LW - 1) ? 2'b01 : 2'b00));
            tick();
        end
        r_idle();

        // async reset with a FULL slot and reads in flight
        arready = 1'b0; m_rd_req = 2'b10; m_burst = 2'b00;
        tick();
        rvalid = 1'b1; rid = '0; rlast = 1'b0;
        chk("pre_reset_arvalid", 64'(arvalid), 64'(1));
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async_arvalid", 64'(arvalid), 64'(0));
        chk("async_payload", 64'({arid, araddr, arlen, arsize, arburst}), 64'(0));
        chk("async_rdy", 64'(m_rd_rdy), 64'(0));
        chk("async_ret_valid", 64'(m_ret_valid), 64'(0));
        chk("async_rid_err", 64'(rid_err), 64'(0));
        @(posedge clk); #1;
        mdl_reset();
        m_rd_req = '0; r_idle(); arready = 1'b1;
        reset = 1'b1;

        // late beat after reset: dropped by counter, flags rid_err
        rvalid = 1'b1; rid = '0; rlast = 1'b1;
        tick();
        r_idle();
        tick();
        chk("late_beat_err", 64'(rid_err), 64'(1));

        // pointer restarts at master 0
        m_rd_req = 2'b11;
        #1;
        chk("rr_after_reset", 64'(m_rd_rdy), 64'(2'b01));
        tick();
        #1;
        chk("rr_next", 64'(m_rd_rdy), 64'(2'b10));
        tick();
        m_rd_req = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Parametrised AXI read-address arbiter and read-data router between NUM_MASTER cache read ports (i-cache, d-cache, future prefetch/TLB walkers) and the single AXI AR/R channel pair. It replaces fixed-priority, single-outstanding read arbitration with three changes:
- round-robin grant;
- per-master ID tagging with R-beat routing by rid;
- per-master outstanding-read counters, allowing up to MAX_OUTS reads in flight per master.

AR is held stable until arready, so the block is AXI-compliant.

## Interface
- NUM_MASTER, 2, number of read requesters; master 0 = i-cache, 1 = d-cache.
- ID_WIDTH, 4, AXI ID width; must be >= $clog2(NUM_MASTER).
- LINE_WORDS, 4, words per cache line; burst arlen = LINE_WORDS-1.
- MAX_OUTS, 2, maximum outstanding reads per master, >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_rd_req  in  NUM_MASTER  read request per master; held until m_rd_rdy.
- m_rd_addr  in  NUM_MASTER*32  request address, master i at [32i+:32].
- m_rd_size  in  NUM_MASTER*2  single-beat size (0=byte, 1=half, 2=word).
- m_burst  in  NUM_MASTER  1 = line-fill INCR burst, 0 = single beat.
- m_rd_rdy  out  NUM_MASTER  one-hot grant pulse; request accepted this cycle.
- m_ret_valid  out  NUM_MASTER  one-hot; R beat belongs to master i.
- m_ret_last  out  1  rlast of current beat.
- m_ret_data  out  32  rdata of current beat.
- m_ret_err  out  1  rresp[1] of current beat (SLVERR/DECERR).
- wr_idle  in  1  write path idle; 0 blocks new grants.
- rid_err  out  1  sticky; R beat received with rid >= NUM_MASTER.
- arid, araddr, arlen, arsize, arburst  out  ID_WIDTH/32/8/3/2  AR payload, registered.
- arlock, arcache, arprot  out  2/4/3  constant 0.
- arvalid  out  1  registered.
- arready  in  1  AR accept.
- rid, rdata, rresp, rlast, rvalid  in  ID_WIDTH/32/2/1/1  R channel.
- rready  out  1  constant 1.

## Operation
AR slot has two states: EMPTY and FULL (arvalid = 1).

Eligibility and grant:
- Master i is eligible when m_rd_req[i] = 1 and cnt[i] < MAX_OUTS.
- A grant may issue when wr_idle = 1 and the slot is EMPTY or draining (arvalid & arready this cycle).
- The winner is the first eligible index at or after rr_ptr, wrapping modulo NUM_MASTER.

Grant actions:
- m_rd_rdy[g] = 1 (combinational).
- Slot loads arid = g (zero-extended), araddr = m_rd_addr[g].
- If m_burst[g] = 1: arburst = INCR (2'b01), arsize = 3'b010, arlen = LINE_WORDS-1.
- If m_burst[g] = 0: arburst = FIXED (2'b00), arsize = {1'b0, m_rd_size[g]}, arlen = 0.
- rr_ptr <= (g+1) mod NUM_MASTER.

Slot behaviour:
- FULL -> EMPTY on arvalid & arready with no new grant; FULL -> FULL on a handshake with a same-cycle grant.
- AR payload never changes while arvalid & !arready.

Outstanding counters, width $clog2(MAX_OUTS+1):
- cnt[i]++ on AR handshake with arid = i.
- cnt[i]-- on rvalid & rlast & rid = i.
- Both in the same cycle: cnt unchanged.
- Decrement at 0 cannot occur legally; cnt saturates at 0 and rid_err sets.

R routing:
- m_ret_valid[i] = rvalid & (rid == i).
- Beats with rid >= NUM_MASTER are dropped and set rid_err.
- Per-master ordering is guaranteed by the same ID; cross-master beats may interleave.

wr_idle = 0 suppresses new grants only. A FULL slot keeps arvalid asserted.

## Timing
- Reset values: arvalid 0, AR payload 0, m_rd_rdy 0, rr_ptr 0, all cnt 0, rid_err 0.
- The AR/R outputs routed from R inputs follow those inputs combinationally.
- Request to arvalid: 1 cycle (grant in cycle t, arvalid high at t+1).
- Sustained throughput: one AR per cycle when arready is held high.
- R to m_ret_*: 0 cycles, combinational.
- Reset asserted mid-burst: all state clears immediately. Late R beats after reset are dropped via cnt = 0 and set rid_err; the system must reset the slave together with this block.

## Structure
- Package axi_pkg: BURST_FIXED, BURST_INCR, SIZE_WORD = 3'b010, RESP_* encodings.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr, en; outputs one-hot gnt[N] and gnt_idx.
- Top contains the AR slot, counters and R demux; 150–300 lines total.

## Test plan
- Single read: master 1 requests, word at 0x1c000010, m_burst = 0, arready = 1. Required: m_rd_rdy[1] in cycle 0; cycle 1 arvalid with arid = 1, arlen = 0, arburst = 0, arsize = 2; one R beat with rid = 1 gives m_ret_valid = 2'b10, and cnt[1] returns to 0.
- Round-robin: both masters request continuously with arready = 1. Required: grants alternate 0, 1, 0, 1; no master is starved.
- Stall: arready = 0 for 5 cycles. Required: arvalid and the full AR payload stay stable; arready rises in cycle 6 and the next grant issues in that same cycle.
- Outstanding limit: MAX_OUTS = 2, master 0 issues 3 bursts with R withheld. Required: third m_rd_rdy held off until the first rlast with rid = 0, then granted that cycle.
- wr_idle = 0 with a pending request: no grant; a FULL slot still completes its handshake. R with rid = 5 when NUM_MASTER = 2: no m_ret_valid and rid_err = 1.
- Reset asserted with arvalid = 1 and cnt = {1, 2}: all outputs and counters are 0 asynchronously, before the next clock edge.
